// File: rtl/prog_loader_if.sv
// Byte-stream / RAM-override bundle between the host link, prog_loader and the RAM.
// master = host side driving the stream, slave = prog_loader.
interface prog_loader_if;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        pc_override;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  modport master (
    output start, rx_data, rx_valid,
    input  rx_ready, pc_override, inst_addr, inst_data, cpu_hold, done, error, words_loaded
  );

  modport slave (
    input  start, rx_data, rx_valid,
    output rx_ready, pc_override, inst_addr, inst_data, cpu_hold, done, error, words_loaded
  );
endinterface

// File: rtl/prog_loader.sv
// Assembles a framed little-endian byte stream into 32-bit words and writes them to RAM.
// Optional trailing XOR checksum byte: define PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 512,
  parameter logic [7:0]  MAGIC     = 8'hA5
) (
  input logic          mem_clk,
  input logic          reset,
  prog_loader_if.slave io_bus
);

  typedef enum logic [3:0] {
    IDLE, SYNC, HDR_LO, HDR_HI, DATA, WRITE,
`ifdef PROG_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE, ERR
  } state_t;

  state_t      r_state;
  logic        r_rxReady;
  logic        r_pcOverride;
  logic [31:0] r_instAddr;
  logic [31:0] r_instData;
  logic        r_cpuHold;
  logic        r_done;
  logic        r_error;
  logic [15:0] r_wordsLoaded;
  logic [15:0] r_count;
  logic [1:0]  r_byteIdx;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]  r_csum;
`endif

  logic        w_accept;
  logic [15:0] w_hdrCount;
  logic [15:0] w_wordsNext;

  assign w_accept    = io_bus.rx_valid & r_rxReady;
  assign w_hdrCount  = {io_bus.rx_data, r_count[7:0]};
  assign w_wordsNext = r_wordsLoaded + 16'd1;

  always_ff @(posedge mem_clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_rxReady     <= 1'b0;
      r_pcOverride  <= 1'b0;
      r_instAddr    <= BASE_ADDR;
      r_instData    <= '0;
      r_cpuHold     <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_wordsLoaded <= '0;
      r_count       <= '0;
      r_byteIdx     <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_csum        <= '0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE, ERR: begin
          if (io_bus.start) begin
            r_state       <= SYNC;
            r_rxReady     <= 1'b1;
            r_cpuHold     <= 1'b1;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_wordsLoaded <= '0;
            r_instAddr    <= BASE_ADDR;
            r_byteIdx     <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_csum        <= '0;
`endif
          end
        end
        SYNC: begin
          if (w_accept && io_bus.rx_data == MAGIC) r_state <= HDR_LO;
        end
        HDR_LO: begin
          if (w_accept) begin
            r_count[7:0] <= io_bus.rx_data;
            r_state      <= HDR_HI;
          end
        end
        HDR_HI: begin
          if (w_accept) begin
            r_count <= w_hdrCount;
            if (w_hdrCount == 16'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              r_state   <= CHK;
`else
              r_state   <= DONE;
              r_rxReady <= 1'b0;
              r_done    <= 1'b1;
              r_cpuHold <= 1'b0;
`endif
            end else if ({16'd0, w_hdrCount} > MAX_WORDS) begin
              r_state   <= ERR;
              r_rxReady <= 1'b0;
              r_error   <= 1'b1;
            end else begin
              r_state   <= DATA;
            end
          end
        end
        DATA: begin
          if (w_accept) begin
            r_instData[{r_byteIdx, 3'b000} +: 8] <= io_bus.rx_data;
            r_byteIdx <= r_byteIdx + 2'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_csum    <= r_csum ^ io_bus.rx_data;
`endif
            if (r_byteIdx == 2'd3) begin
              r_state      <= WRITE;
              r_rxReady    <= 1'b0;
              r_pcOverride <= 1'b1;
            end
          end
        end
        WRITE: begin
          r_pcOverride  <= 1'b0;
          r_wordsLoaded <= w_wordsNext;
          r_instAddr    <= r_instAddr + 32'd4;
          if (w_wordsNext == r_count) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            r_state   <= CHK;
            r_rxReady <= 1'b1;
`else
            r_state   <= DONE;
            r_done    <= 1'b1;
            r_cpuHold <= 1'b0;
`endif
          end else begin
            r_state   <= DATA;
            r_rxReady <= 1'b1;
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        CHK: begin
          if (w_accept) begin
            r_rxReady <= 1'b0;
            if (io_bus.rx_data == r_csum) begin
              r_state   <= DONE;
              r_done    <= 1'b1;
              r_cpuHold <= 1'b0;
            end else begin
              r_state   <= ERR;
              r_error   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Masking with reset keeps the RAM from latching a write at the same edge that resets us.
  assign io_bus.pc_override  = r_pcOverride & ~reset;
  assign io_bus.rx_ready     = r_rxReady;
  assign io_bus.inst_addr    = r_instAddr;
  assign io_bus.inst_data    = r_instData;
  assign io_bus.cpu_hold     = r_cpuHold;
  assign io_bus.done         = r_done;
  assign io_bus.error        = r_error;
  assign io_bus.words_loaded = r_wordsLoaded;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table vectors, hand-written reset/hold sequences,
// and random frames checked against a frame-parsing reference model.
module tb_prog_loader;

  localparam logic [7:0]  MAGIC     = 8'hA5;
  localparam int          MAX_WORDS = 512;
  localparam logic [31:0] BASE1     = 32'h0000_0100;

  logic mem_clk = 1'b0;
  logic reset   = 1'b1;
  always #5 mem_clk = ~mem_clk;

  prog_loader_if bus0 ();
  prog_loader_if bus1 ();

  // The second instance sees the same stream but loads at a different base address.
  assign bus1.start    = bus0.start;
  assign bus1.rx_data  = bus0.rx_data;
  assign bus1.rx_valid = bus0.rx_valid;

  prog_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(MAX_WORDS), .MAGIC(MAGIC)) dut0 (
    .mem_clk(mem_clk), .reset(reset), .io_bus(bus0)
  );
  prog_loader #(.BASE_ADDR(BASE1), .MAX_WORDS(MAX_WORDS), .MAGIC(MAGIC)) dut1 (
    .mem_clk(mem_clk), .reset(reset), .io_bus(bus1)
  );

  int nChecks = 0;
  int nPassed = 0;
  int backToBack = 0;
  logic prevOv0 = 1'b0;
  logic [63:0] got0[$];
  logic [63:0] got1[$];
  logic [7:0]  stim[$];

  always @(negedge mem_clk) begin
    if (bus0.pc_override) begin
      got0.push_back({bus0.inst_addr, bus0.inst_data});
      if (prevOv0) backToBack++;
    end
    if (bus1.pc_override) got1.push_back({bus1.inst_addr, bus1.inst_data});
    prevOv0 = bus0.pc_override;
  end

  typedef struct {
    string        name;
    logic [127:0] raw;
    int           nBytes;
    int           gap;
    logic         expDone;
    logic         expError;
    int           expWords;
    logic [31:0]  expFirst;
    logic [31:0]  expLast;
  } vec_t;
  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPassed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  function automatic logic [7:0] xorData();
    int i = 0;
    logic [7:0] x = 8'h00;
    while (i < stim.size() && stim[i] != MAGIC) i++;
    for (int j = i + 3; j < stim.size(); j++) x ^= stim[j];
    return x;
  endfunction
`endif

  task automatic sendByte(input logic [7:0] b, input int gap);
    bit taken = 1'b0;
    bus0.rx_valid = 1'b0;
    repeat (gap) begin @(posedge mem_clk); #1; end
    bus0.rx_valid = 1'b1;
    bus0.rx_data  = b;
    for (int t = 0; t < 40 && !taken; t++) begin
      @(negedge mem_clk);
      taken = bus0.rx_ready;
      @(posedge mem_clk); #1;
    end
    bus0.rx_valid = 1'b0;
    if (!taken) checkOutput("byte_accept", {31'd0, taken}, 32'd1);
  endtask

  task automatic applyStimulus(input int gapMin, input int gapMax);
    bus0.start = 1'b1;
    @(posedge mem_clk); #1;
    bus0.start = 1'b0;
    checkOutput("start_clears_words", {16'd0, bus0.words_loaded}, 32'd0);
    checkOutput("start_clears_flags", {30'd0, bus0.done, bus0.error}, 32'd0);
    foreach (stim[i]) sendByte(stim[i], $urandom_range(gapMax, gapMin));
  endtask

  task automatic waitEnd();
    int t = 0;
    while (!(bus0.done || bus0.error) && t < 50) begin
      @(posedge mem_clk); #1;
      t++;
    end
    checkOutput("frame_end", {31'd0, bus0.done | bus0.error}, 32'd1);
    @(negedge mem_clk);
  endtask

  task automatic clearMonitor();
    got0.delete();
    got1.delete();
    backToBack = 0;
  endtask

  // Reference: parse the frame from the byte list and derive the writes and the outcome.
  task automatic runModelFrame(input int gapMax);
    logic [63:0] exp[$];
    logic [15:0] cnt;
    logic [31:0] word;
    logic [7:0]  x = 8'h00;
    bit          expErr = 1'b0;
    int          i = 0;
    int          mism = 0;
    int          mism1 = 0;
    clearMonitor();
    applyStimulus(0, gapMax);
    waitEnd();
    while (i < stim.size() && stim[i] != MAGIC) i++;
    cnt = {stim[i+2], stim[i+1]};
    i += 3;
    if (cnt > MAX_WORDS) expErr = 1'b1;
    else begin
      for (int k = 0; k < int'(cnt); k++) begin
        word = {stim[i+3], stim[i+2], stim[i+1], stim[i]};
        exp.push_back({32'(4 * k), word});
        x ^= stim[i] ^ stim[i+1] ^ stim[i+2] ^ stim[i+3];
        i += 4;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      expErr = (stim[i] != x);
`endif
    end
    checkOutput("rand_done", {31'd0, bus0.done}, {31'd0, !expErr});
    checkOutput("rand_error", {31'd0, bus0.error}, {31'd0, expErr});
    checkOutput("rand_cpu_hold", {31'd0, bus0.cpu_hold}, {31'd0, expErr});
    checkOutput("rand_words", {16'd0, bus0.words_loaded}, 32'(exp.size()));
    checkOutput("rand_nwrites", 32'(got0.size()), 32'(exp.size()));
    for (int k = 0; k < exp.size() && k < got0.size() && k < got1.size(); k++) begin
      if (got0[k] !== exp[k]) begin
        if (mism == 0) $display("[TB] write %0d: got %016h, expected %016h", k, got0[k], exp[k]);
        mism++;
      end
      if (got1[k] !== {exp[k][63:32] + BASE1, exp[k][31:0]}) mism1++;
    end
    checkOutput("rand_write_content", 32'(mism), 32'd0);
    checkOutput("rand_write_base1", 32'(mism1), 32'd0);
    checkOutput("rand_no_back_to_back", 32'(backToBack), 32'd0);
  endtask

  task automatic runRandomFrame(input int forceCount);
    int cnt;
    int mode;
    logic [7:0] b;
    stim.delete();
    repeat ($urandom_range(2, 0)) begin
      b = 8'($urandom());
      if (b == MAGIC) b = 8'h5A;
      stim.push_back(b);
    end
    stim.push_back(MAGIC);
    if (forceCount >= 0) cnt = forceCount;
    else begin
      mode = $urandom_range(9, 0);
      if (mode == 0) cnt = 0;
      else if (mode == 1) cnt = 513 + $urandom_range(3000, 0);
      else cnt = $urandom_range(5, 1);
    end
    stim.push_back(8'(cnt));
    stim.push_back(8'(cnt >> 8));
    if (cnt <= MAX_WORDS) begin
      repeat (4 * cnt) stim.push_back(8'($urandom()));
`ifdef PROG_LOADER_CHECKSUM_EN
      b = xorData();
      if ($urandom_range(4, 0) == 0) b ^= 8'(1 << $urandom_range(7, 0));
      stim.push_back(b);
`endif
    end
    runModelFrame(forceCount >= 0 ? 0 : $urandom_range(2, 0));
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{"two_word",     128'h00A50200_78563412_EFBEADDE, 12, 0, 1'b1, 1'b0, 2, 32'h12345678, 32'hDEADBEEF};
    vecs[1] = '{"toggle_valid", 128'h00A50200_78563412_EFBEADDE, 12, 1, 1'b1, 1'b0, 2, 32'h12345678, 32'hDEADBEEF};
    vecs[2] = '{"count_513",    128'hA50102,                      3, 0, 1'b0, 1'b1, 0, 32'h0, 32'h0};
    vecs[3] = '{"count_zero",   128'hA50000,                      3, 0, 1'b1, 1'b0, 0, 32'h0, 32'h0};
    vecs[4] = '{"junk_sync",    128'h1122A5010001020304,          9, 0, 1'b1, 1'b0, 1, 32'h04030201, 32'h04030201};
    vecs[5] = '{"hdr_ffff",     128'hA5FFFF,                      3, 1, 1'b0, 1'b1, 0, 32'h0, 32'h0};

    bus0.start = 1'b0;
    bus0.rx_valid = 1'b0;
    bus0.rx_data = 8'h00;
    reset = 1'b1;
    repeat (3) @(posedge mem_clk);
    #1 reset = 1'b0;
    @(negedge mem_clk);
    checkOutput("rst_rx_ready", {31'd0, bus0.rx_ready}, 32'd0);
    checkOutput("rst_pc_override", {31'd0, bus0.pc_override}, 32'd0);
    checkOutput("rst_inst_addr", bus0.inst_addr, 32'h0);
    checkOutput("rst_inst_addr_base1", bus1.inst_addr, BASE1);
    checkOutput("rst_inst_data", bus0.inst_data, 32'h0);
    checkOutput("rst_flags", {29'd0, bus0.cpu_hold, bus0.done, bus0.error}, 32'd0);
    checkOutput("rst_words", {16'd0, bus0.words_loaded}, 32'd0);

    // Reset after two bytes of the first word.
    clearMonitor();
    stim.delete();
    bus0.start = 1'b1;
    @(posedge mem_clk); #1;
    bus0.start = 1'b0;
    foreach (stim[i]) sendByte(stim[i], 0);
    sendByte(8'hA5, 0); sendByte(8'h02, 0); sendByte(8'h00, 0);
    sendByte(8'h78, 0); sendByte(8'h56, 0);
    checkOutput("mid_data_hold", {31'd0, bus0.cpu_hold}, 32'd1);
    reset = 1'b1;
    @(posedge mem_clk); #1;
    reset = 1'b0;
    @(negedge mem_clk);
    checkOutput("mid_rst_rx_ready", {31'd0, bus0.rx_ready}, 32'd0);
    checkOutput("mid_rst_cpu_hold", {31'd0, bus0.cpu_hold}, 32'd0);
    checkOutput("mid_rst_inst_data", bus0.inst_data, 32'h0);
    checkOutput("mid_rst_inst_addr", bus0.inst_addr, 32'h0);
    checkOutput("mid_rst_no_write", 32'(got0.size()), 32'd0);

    // Reset asserted during the WRITE cycle must suppress the write.
    bus0.start = 1'b1;
    @(posedge mem_clk); #1;
    bus0.start = 1'b0;
    sendByte(8'hA5, 0); sendByte(8'h01, 0); sendByte(8'h00, 0);
    sendByte(8'h11, 0); sendByte(8'h22, 0); sendByte(8'h33, 0); sendByte(8'h44, 0);
    reset = 1'b1;
    @(negedge mem_clk);
    checkOutput("wr_rst_pc_override", {31'd0, bus0.pc_override}, 32'd0);
    @(posedge mem_clk); #1;
    reset = 1'b0;
    @(negedge mem_clk);
    checkOutput("wr_rst_no_write", 32'(got0.size()), 32'd0);
    checkOutput("wr_rst_words", {16'd0, bus0.words_loaded}, 32'd0);
    checkOutput("wr_rst_cpu_hold", {31'd0, bus0.cpu_hold}, 32'd0);

    for (int v = 0; v < 6; v++) begin
      stim.delete();
      for (int i = 0; i < vecs[v].nBytes; i++)
        stim.push_back(vecs[v].raw[8 * (vecs[v].nBytes - 1 - i) +: 8]);
`ifdef PROG_LOADER_CHECKSUM_EN
      if (vecs[v].expDone) stim.push_back(xorData());
`endif
      clearMonitor();
      applyStimulus(vecs[v].gap, vecs[v].gap);
      waitEnd();
      checkOutput({vecs[v].name, "_done"}, {31'd0, bus0.done}, {31'd0, vecs[v].expDone});
      checkOutput({vecs[v].name, "_error"}, {31'd0, bus0.error}, {31'd0, vecs[v].expError});
      checkOutput({vecs[v].name, "_cpu_hold"}, {31'd0, bus0.cpu_hold}, {31'd0, vecs[v].expError});
      checkOutput({vecs[v].name, "_words"}, {16'd0, bus0.words_loaded}, 32'(vecs[v].expWords));
      checkOutput({vecs[v].name, "_words_base1"}, {16'd0, bus1.words_loaded}, 32'(vecs[v].expWords));
      checkOutput({vecs[v].name, "_nwrites"}, 32'(got0.size()), 32'(vecs[v].expWords));
      checkOutput({vecs[v].name, "_b2b"}, 32'(backToBack), 32'd0);
      if (vecs[v].expWords > 0 && got0.size() > 0 && got1.size() > 0) begin
        checkOutput({vecs[v].name, "_first_addr"}, got0[0][63:32], 32'h0);
        checkOutput({vecs[v].name, "_first_data"}, got0[0][31:0], vecs[v].expFirst);
        checkOutput({vecs[v].name, "_last_addr"}, got0[got0.size()-1][63:32], 32'(4 * (vecs[v].expWords - 1)));
        checkOutput({vecs[v].name, "_last_data"}, got0[got0.size()-1][31:0], vecs[v].expLast);
        checkOutput({vecs[v].name, "_first_addr_base1"}, got1[0][63:32], BASE1);
      end
    end

    // A byte offered while DONE must not be consumed.
    stim.delete();
    stim.push_back(8'hA5); stim.push_back(8'h01); stim.push_back(8'h00);
    stim.push_back(8'h01); stim.push_back(8'h02); stim.push_back(8'h03); stim.push_back(8'h04);
`ifdef PROG_LOADER_CHECKSUM_EN
    stim.push_back(xorData());
`endif
    clearMonitor();
    applyStimulus(0, 0);
    waitEnd();
    bus0.rx_valid = 1'b1;
    bus0.rx_data  = MAGIC;
    repeat (4) @(negedge mem_clk);
    checkOutput("done_hold_rx_ready", {31'd0, bus0.rx_ready}, 32'd0);
    checkOutput("done_hold_done", {31'd0, bus0.done}, 32'd1);
    checkOutput("done_hold_words", {16'd0, bus0.words_loaded}, 32'd1);
    checkOutput("done_hold_addr", bus0.inst_addr, 32'h4);
    checkOutput("done_hold_nwrites", 32'(got0.size()), 32'd1);
    bus0.rx_valid = 1'b0;

`ifdef PROG_LOADER_CHECKSUM_EN
    // Two-word frame with a wrong checksum: the XOR of its data bytes is 0x2A.
    stim.delete();
    stim.push_back(8'hA5); stim.push_back(8'h02); stim.push_back(8'h00);
    stim.push_back(8'h78); stim.push_back(8'h56); stim.push_back(8'h34); stim.push_back(8'h12);
    stim.push_back(8'hEF); stim.push_back(8'hBE); stim.push_back(8'hAD); stim.push_back(8'hDE);
    stim.push_back(8'h2B);
    clearMonitor();
    applyStimulus(0, 0);
    waitEnd();
    checkOutput("bad_csum_error", {31'd0, bus0.error}, 32'd1);
    checkOutput("bad_csum_done", {31'd0, bus0.done}, 32'd0);
    checkOutput("bad_csum_words", {16'd0, bus0.words_loaded}, 32'd2);
    checkOutput("bad_csum_nwrites", 32'(got0.size()), 32'd2);
`endif

    for (int r = 0; r < 25; r++) runRandomFrame(-1);
    runRandomFrame(MAX_WORDS);
    runRandomFrame(MAX_WORDS + 1);

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
